// File: rtl/branch_unit_ctrl_pkg.sv
// Shared ZAFx32 branch-unit definitions: FSM encoding, 2-bit counter constants
// and the beq/bne branch-type encoding.
package zafx32_pkg;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  localparam logic [1:0] CNT_RESET = 2'b01;
  localparam logic [1:0] CNT_MAX   = 2'b11;
  localparam logic [1:0] CNT_MIN   = 2'b00;

  localparam logic BRTYPE_EQ = 1'b1;
  localparam logic BRTYPE_NE = 1'b0;

endpackage

// File: rtl/branch_unit_ctrl_bht_sat2.sv
// Branch history table of 2-bit saturating counters: one combinational read
// port, one synchronous update port, synchronous active-low reset.
module bht_sat2
  import zafx32_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0] cnt [DEPTH];

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
    if (taken) return (c == CNT_MAX) ? CNT_MAX : c + 2'd1;
    else       return (c == CNT_MIN) ? CNT_MIN : c - 2'd1;
  endfunction

  // Read returns the pre-update value on a same-index collision (no bypass).
  assign rd_cnt = cnt[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) cnt[i] <= CNT_RESET;
    end else if (upd_en) begin
      cnt[upd_idx] <= sat_step(cnt[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/branch_unit_ctrl.sv
// ZAFx32 branch scheduler: IF prediction, EX resolution, table training and
// one-cycle registered redirect/flush. Optional counters under BRANCH_STATS_EN.
module branch_unit_ctrl
  import zafx32_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] if_pc,
  input  logic            if_is_branch,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_branchtype,
  input  logic            ex_zero,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_target,
  input  logic [PC_W-1:0] ex_pc_plus4,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush_ifid,
  output logic            flush_idex
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  state_t     state;
  logic [1:0] if_cnt;
  logic       actual;
  logic       resolve;
  logic       mispredict;
  logic       unused_pc_bits;

  assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                            ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

  bht_sat2 #(.IDX_W(IDX_W)) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (if_pc[IDX_W+1:2]),
    .rd_cnt    (if_cnt),
    .upd_en    (resolve),
    .upd_idx   (ex_pc[IDX_W+1:2]),
    .upd_taken (actual)
  );

  assign pred_taken = if_is_branch & if_cnt[1] & (state == S_RUN);

  // EX resolution; the wrong-path instruction seen during S_FLUSH is ignored.
  assign actual     = (ex_branchtype == BRTYPE_EQ) ? ex_zero : ~ex_zero;
  assign resolve    = ex_valid & ex_branch & (state == S_RUN);
  assign mispredict = resolve & (actual != ex_pred_taken);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_RUN;
      redirect    <= 1'b0;
      flush_ifid  <= 1'b0;
      flush_idex  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (mispredict) begin
            state       <= S_FLUSH;
            redirect    <= 1'b1;
            flush_ifid  <= 1'b1;
            flush_idex  <= 1'b1;
            redirect_pc <= actual ? ex_target : ex_pc_plus4;
          end
        end
        S_FLUSH: begin
          state      <= S_RUN;
          redirect   <= 1'b0;
          flush_ifid <= 1'b0;
          flush_idex <= 1'b0;
        end
        default: state <= S_RUN;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (resolve)    stat_branches    <= stat_branches + 32'd1;
      if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_unit_ctrl.sv
// Directed self-checking bench for branch_unit_ctrl (stats checks active when
// BRANCH_STATS_EN is defined).
module tb_branch_unit_ctrl;

  localparam int IDX_W = 4;
  localparam int PC_W  = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [PC_W-1:0] if_pc;
  logic            if_is_branch;
  logic            pred_taken;
  logic            ex_valid, ex_branch, ex_branchtype, ex_zero, ex_pred_taken;
  logic [PC_W-1:0] ex_pc, ex_target, ex_pc_plus4;
  logic            redirect, flush_ifid, flush_idex;
  logic [PC_W-1:0] redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0]     stat_branches, stat_mispredicts;
`endif

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  branch_unit_ctrl #(.IDX_W(IDX_W), .PC_W(PC_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_pc         (if_pc),
    .if_is_branch  (if_is_branch),
    .pred_taken    (pred_taken),
    .ex_valid      (ex_valid),
    .ex_branch     (ex_branch),
    .ex_branchtype (ex_branchtype),
    .ex_zero       (ex_zero),
    .ex_pc         (ex_pc),
    .ex_pred_taken (ex_pred_taken),
    .ex_target     (ex_target),
    .ex_pc_plus4   (ex_pc_plus4),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .flush_ifid    (flush_ifid),
    .flush_idex    (flush_idex)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobes(input string tag, input logic exp, input logic [31:0] pc);
    chk({tag, ".redirect"},    {31'd0, redirect},   {31'd0, exp});
    chk({tag, ".flush_ifid"},  {31'd0, flush_ifid}, {31'd0, exp});
    chk({tag, ".flush_idex"},  {31'd0, flush_idex}, {31'd0, exp});
    chk({tag, ".redirect_pc"}, redirect_pc,         pc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ex();
    ex_valid = 0; ex_branch = 0; ex_branchtype = 0; ex_zero = 0;
    ex_pred_taken = 0; ex_pc = '0; ex_target = '0; ex_pc_plus4 = '0;
  endtask

  task automatic br(input logic btype, input logic zero, input logic pt,
                    input logic [31:0] pc, input logic [31:0] tgt);
    ex_valid = 1; ex_branch = 1; ex_branchtype = btype; ex_zero = zero;
    ex_pred_taken = pt; ex_pc = pc; ex_target = tgt; ex_pc_plus4 = pc + 32'd4;
  endtask

  task automatic pred(input string tag, input logic [31:0] pc, input logic isb, input logic exp);
    if_pc = pc; if_is_branch = isb;
    #1;
    chk(tag, {31'd0, pred_taken}, {31'd0, exp});
  endtask

  initial begin
    rst_n = 0; if_pc = '0; if_is_branch = 0;
    idle_ex();
    step(); step();
    rst_n = 1;
    strobes("reset", 1'b0, 32'h0);
    pred("reset_pred_0x40", 32'h40, 1'b1, 1'b0);

    // beq taken, predicted not-taken: mispredict to target; counter[0] 01->10
    br(1'b1, 1'b1, 1'b0, 32'h40, 32'h100);
    step();
    strobes("beq_mp", 1'b1, 32'h100);
    pred("pred_forced0_in_flush", 32'h40, 1'b1, 1'b0);
    step();
    idle_ex();
    strobes("beq_mp_after", 1'b0, 32'h100);
    pred("pred_0x40_after_one", 32'h40, 1'b1, 1'b1);
    pred("pred_gated_no_branch", 32'h40, 1'b0, 1'b0);

    // Three more correctly predicted takens: 10->11->11->11
    for (int i = 0; i < 3; i++) begin
      br(1'b1, 1'b1, 1'b1, 32'h40, 32'h100);
      step();
      strobes($sformatf("beq_ok%0d", i), 1'b0, 32'h100);
    end
    idle_ex();
    pred("pred_0x40_sat", 32'h40, 1'b1, 1'b1);

    // Not-taken once: 11->10 still predicts taken (catches counter wrap)
    br(1'b1, 1'b0, 1'b1, 32'h40, 32'h100);
    step();
    strobes("beq_nt1", 1'b1, 32'h44);
    idle_ex();
    step();
    pred("pred_0x40_10", 32'h40, 1'b1, 1'b1);
    br(1'b1, 1'b0, 1'b1, 32'h40, 32'h100);
    step();
    strobes("beq_nt2", 1'b1, 32'h44);
    idle_ex();
    step();
    pred("pred_0x40_01", 32'h40, 1'b1, 1'b0);

    // bne with zero=1 (not taken), predicted taken: redirect to 0x84; ctr[0] 01->00
    br(1'b0, 1'b1, 1'b1, 32'h80, 32'h200);
    step();
    strobes("bne_mp", 1'b1, 32'h84);
    // Wrong-path taken beq in EX during S_FLUSH: must not train nor redirect
    br(1'b1, 1'b1, 1'b0, 32'h80, 32'h400);
    step();
    idle_ex();
    strobes("flush_wrongpath", 1'b0, 32'h84);
    // Taken resolve on ctr[0]: 00->01 predicts 0; a trained flush would give 10
    br(1'b1, 1'b1, 1'b0, 32'h80, 32'h200);
    step();
    strobes("bne_followup", 1'b1, 32'h200);
    idle_ex();
    step();
    pred("pred_no_wrongpath_train", 32'h40, 1'b1, 1'b0);

    // Back-to-back correct resolves on two indices train independently
    br(1'b1, 1'b1, 1'b1, 32'h44, 32'h500);
    step();
    strobes("b2b_a", 1'b0, 32'h200);
    br(1'b0, 1'b0, 1'b1, 32'h48, 32'h500);
    step();
    strobes("b2b_b", 1'b0, 32'h200);
    idle_ex();
    pred("pred_b2b_0x44", 32'h44, 1'b1, 1'b1);
    pred("pred_b2b_0x48", 32'h48, 1'b1, 1'b1);
    pred("pred_b2b_0x4c", 32'h4C, 1'b1, 1'b0);

    // Same-cycle read/write of index 3: read sees the old value
    br(1'b1, 1'b1, 1'b1, 32'h4C, 32'h500);
    pred("pred_no_bypass", 32'h4C, 1'b1, 1'b0);
    step();
    idle_ex();
    pred("pred_after_write", 32'h4C, 1'b1, 1'b1);

    // Mispredict, then reset during S_FLUSH
    br(1'b1, 1'b0, 1'b1, 32'h48, 32'h500);
    step();
    strobes("pre_rst_mp", 1'b1, 32'h4C);
    idle_ex();
    rst_n = 0;
    step();
    rst_n = 1;
    strobes("rst_in_flush", 1'b0, 32'h0);
    pred("rst_ctr_0x44", 32'h44, 1'b1, 1'b0);
    pred("rst_ctr_0x4c", 32'h4C, 1'b1, 1'b0);

    // Three resolves, one mispredict; the mispredict also proves FSM is S_RUN
    br(1'b1, 1'b1, 1'b1, 32'h50, 32'h300);
    step();
    strobes("res_a", 1'b0, 32'h0);
    br(1'b1, 1'b0, 1'b0, 32'h54, 32'h300);
    step();
    strobes("res_b", 1'b0, 32'h0);
    br(1'b0, 1'b0, 1'b0, 32'h58, 32'h300);
    step();
    idle_ex();
    strobes("res_c_mp", 1'b1, 32'h300);
    step();
    strobes("res_c_after", 1'b0, 32'h300);
`ifdef BRANCH_STATS_EN
    chk("stat_branches",    stat_branches,    32'd3);
    chk("stat_mispredicts", stat_mispredicts, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/branch_unit_ctrl.md
Name: branch_unit_ctrl

Overview:
- Branch scheduler for the ZAFx32 pipeline.
- Predicts beq/bne direction at IF using a table of 2-bit saturating counters, indexed by PC.
- Resolves the branch in EX with the same jeq/jne selection the datapath uses (branchtype=1: taken on zero; branchtype=0: taken on not-zero).
- Trains the table and, on a mispredict, sequences a registered redirect plus IF/ID and ID/EX flush.

Parameters:
- IDX_W, 4, table index width; table holds 2^IDX_W counters, indexed by pc[IDX_W+1:2].
- PC_W, 32, program-counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- if_pc  in  PC_W  PC of the instruction in IF.
- if_is_branch  in  1  IF predecode: instruction is beq/bne.
- pred_taken  out  1  combinational prediction for the IF instruction.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_branch  in  1  EX instruction is beq/bne.
- ex_branchtype  in  1  1 = beq (jeq), 0 = bne (jne).
- ex_zero  in  1  ALU zero flag of the EX compare.
- ex_pc  in  PC_W  PC of the EX instruction (table update index).
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- ex_target  in  PC_W  computed branch target.
- ex_pc_plus4  in  PC_W  fall-through address.
- redirect  out  1  registered: load PC from redirect_pc this cycle.
- redirect_pc  out  PC_W  registered correct-path address.
- flush_ifid  out  1  registered: squash IF/ID.
- flush_idex  out  1  registered: squash ID/EX.

Behaviour:
- Clocking/reset: one clock, clk. Reset rst_n is synchronous and active-low. While rst_n=0 at a rising edge:
  - redirect, flush_ifid, flush_idex <= 0; redirect_pc <= 0.
  - FSM <= S_RUN.
  - All counters <= 2'b01 (weakly not-taken).
- Prediction:
  - pred_taken = if_is_branch & BHT[if_pc[IDX_W+1:2]][1]; purely combinational.
  - Forced to 0 while FSM = S_FLUSH.
- Resolution (combinational in EX):
  - actual = ex_branchtype ? ex_zero : ~ex_zero.
  - resolve = ex_valid & ex_branch & (FSM == S_RUN).
  - mispredict = resolve & (actual != ex_pred_taken).
- Training:
  - On resolve, at the clock edge, counter BHT[ex_pc[IDX_W+1:2]] increments if actual=1, decrements if actual=0.
  - Counters saturate at 2'b11 and 2'b00.
  - Same-cycle read and write of the same index: pred_taken uses the old value (no bypass).
- FSM, two states:
  - S_RUN -> S_FLUSH on mispredict.
  - S_FLUSH -> S_RUN unconditionally after 1 cycle.
- Mispredict timing, with the mispredict detected in cycle N:
  - In cycle N+1 (FSM = S_FLUSH): redirect=1, flush_ifid=1, flush_idex=1, redirect_pc = actual ? ex_target : ex_pc_plus4, latched at the end of N.
  - In cycle N+2: all three strobes return to 0.
  - redirect_pc holds its last value when redirect=0.
- Wrong-path handling: in S_FLUSH, ex_valid/ex_branch are ignored. The wrong-path EX instruction neither trains the table nor triggers a mispredict.
- Correct predictions produce no strobes and no stall. Latency of redirect from EX detect is 1 cycle.
- Back-to-back branches resolving in consecutive S_RUN cycles are each trained independently.
- Reset asserted in S_FLUSH: strobes are 0 in the next cycle and the FSM is S_RUN; no redirect is issued.
- Width rules:
  - PC indices use bits [IDX_W+1:2]; bits [1:0] are ignored.
  - No arithmetic on PCs inside the block.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: adds two 32-bit output ports.
  - stat_branches: counts resolve events.
  - stat_mispredicts: counts mispredict events.
  - Both counters reset to 0 on rst_n=0 and wrap modulo 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package (zafx32_pkg):
  - FSM state encoding: S_RUN=1'b0, S_FLUSH=1'b1.
  - Counter constants: CNT_RESET=2'b01, CNT_MAX=2'b11, CNT_MIN=2'b00.
  - BRTYPE_EQ=1'b1, BRTYPE_NE=1'b0.
- One sub-module: bht_sat2, the counter table with one combinational read port, one synchronous update port and synchronous reset.
- The FSM and redirect registers stay in branch_unit_ctrl.

Test Plan:
- Reset, then if_pc=0x40 with if_is_branch=1 -> pred_taken=0. Strobes are 0 and redirect_pc=0 from the first post-reset cycle.
- Resolve beq: ex_zero=1, ex_pred_taken=0, ex_target=0x100, ex_pc=0x40 -> next cycle redirect=flush_ifid=flush_idex=1 with redirect_pc=0x100. The cycle after, all strobes are 0.
- Same beq at 0x40 taken twice more -> counter index 0x0 reaches 2'b11. A fourth taken resolve stays at 2'b11 (saturation), and pred_taken=1 at if_pc=0x40.
- Resolve bne: ex_zero=1, ex_pred_taken=1, ex_pc_plus4=0x84 -> redirect_pc=0x84. A branch presented in EX during the S_FLUSH cycle causes no training and no second redirect.
- Drive rst_n=0 in the S_FLUSH cycle -> next cycle strobes are 0, FSM is S_RUN, and counters are 2'b01.
- With BRANCH_STATS_EN: 3 resolves containing 1 mispredict -> stat_branches=3, stat_mispredicts=1.
